sdram_stream_writer: RTL and testbench

Upstream AXI4 write master for the SDRAM controller's AXI4 slave port. It accepts a 32-bit valid/ready word stream, buffers it in an internal FIFO and writes a programmed number of words to SDRAM as AXI4 INCR bursts. Its main use is frame capture, for example camera or ADC data into SDRAM, with one burst outstanding at a time.

---
 rtl/sdram_stream_writer.sv | 207 ++++++++++++++++++++
 tb/tb_sdram_stream_writer.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_stream_writer.sv
// Buffers a 32-bit valid/ready stream in a FIFO and writes a programmed number
// of words to SDRAM as AXI4 INCR bursts, one burst outstanding at a time.
module sdram_stream_writer #(
  parameter int unsigned BURST_LEN  = 16,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter logic [3:0]  AXI_ID     = 4'd0
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] base_addr_i,
  input  logic [23:0] len_i,
  input  logic        s_valid_i,
  input  logic [31:0] s_data_i,
  output logic        s_ready_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [31:0] awaddr_o,
  output logic [3:0]  awid_o,
  output logic [7:0]  awlen_o,
  output logic [1:0]  awburst_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wlast_o,
  input  logic        bvalid_i,
  output logic        bready_o,
  input  logic [1:0]  bresp_i,
  input  logic [3:0]  bid_i
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ALIGN_W = $clog2(BURST_LEN * 4);
  localparam logic [23:0]      BURST_WORDS = 24'(BURST_LEN);
  localparam logic [CNT_W-1:0] FIFO_FULL   = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_ADDR, S_DATA, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [23:0]       rem_q, rem_d;
  logic [23:0]       acc_q, acc_d;
  logic [31:0]       addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              awvalid_q, awvalid_d;
  logic [31:0]       awaddr_q, awaddr_d;
  logic [7:0]        awlen_q, awlen_d;
  logic [7:0]        beat_q, beat_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [31:0]       mem_q [FIFO_DEPTH];

  logic        push, pop;
  logic [23:0] beats;
  logic [8:0]  burst_words;
  logic        unused_inputs;

  // Response ID and the forced-zero address bits carry no information here.
  assign unused_inputs = ^{bid_i, base_addr_i[ALIGN_W-1:0]};

  assign awburst_o = 2'b01;
  assign wstrb_o   = 4'hF;
  assign awid_o    = AXI_ID;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign error_o   = error_q;
  assign awvalid_o = awvalid_q;
  assign awaddr_o  = awaddr_q;
  assign awlen_o   = awlen_q;

  assign s_ready_o = busy_q & (acc_q != 24'd0) & (count_q != FIFO_FULL);
  assign wvalid_o  = (state_q == S_DATA);
  assign wlast_o   = wvalid_o & (beat_q == awlen_q);
  assign wdata_o   = wvalid_o ? mem_q[rd_ptr_q] : 32'h0;
  assign bready_o  = (state_q == S_RESP);

  assign push        = s_valid_i & s_ready_o;
  assign pop         = wvalid_o & wready_i;
  assign beats       = (rem_q < BURST_WORDS) ? rem_q : BURST_WORDS;
  assign burst_words = {1'b0, awlen_q} + 9'd1;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    rem_d     = rem_q;
    acc_d     = acc_q;
    addr_d    = addr_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = error_q;
    awvalid_d = awvalid_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    beat_d    = beat_q;
    count_d   = count_q;

    if (push) acc_d = acc_q - 24'd1;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          addr_d  = {base_addr_i[31:ALIGN_W], ALIGN_W'(0)};
          rem_d   = len_i;
          acc_d   = len_i;
          error_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (rem_q == 24'd0) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (24'(count_q) >= beats) begin
          awaddr_d  = addr_q;
          awlen_d   = 8'(beats - 24'd1);
          awvalid_d = 1'b1;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (awready_i) begin
          awvalid_d = 1'b0;
          addr_d    = addr_q + {21'b0, burst_words, 2'b00};
          rem_d     = rem_q - {15'b0, burst_words};
          beat_d    = 8'd0;
          state_d   = S_DATA;
        end
      end
      S_DATA: begin
        if (wready_i) begin
          beat_d = beat_q + 8'd1;
          if (wlast_o) state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (bvalid_i) begin
          if (bresp_i != 2'b00) error_d = 1'b1;
          // Finishing straight from RESP puts done_o one cycle after the last B.
          if (rem_q == 24'd0) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_FILL;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      acc_q     <= '0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      awvalid_q <= 1'b0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      beat_q    <= '0;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q   <= state_d;
      rem_q     <= rem_d;
      acc_q     <= acc_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
      awvalid_q <= awvalid_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
      beat_q    <= beat_d;
      count_q   <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  // NOTE: FIFO storage is deliberately not reset; count and pointers define
  // which entries are valid, so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= s_data_i;
  end

endmodule

// File: tb/tb_sdram_stream_writer.sv
// Directed bench for sdram_stream_writer: a scoreboard queues expected AW
// bursts and stream words, and compares them as the AXI channels handshake.
module tb_sdram_stream_writer;

  localparam int BURST_LEN  = 16;
  localparam int FIFO_DEPTH = 32;

  logic        clk_i, rst_i, start_i;
  logic [31:0] base_addr_i;
  logic [23:0] len_i;
  logic        s_valid_i, s_ready_o;
  logic [31:0] s_data_i;
  logic        busy_o, done_o, error_o;
  logic        awvalid_o, awready_i;
  logic [31:0] awaddr_o;
  logic [3:0]  awid_o;
  logic [7:0]  awlen_o;
  logic [1:0]  awburst_o;
  logic        wvalid_o, wready_i, wlast_o;
  logic [31:0] wdata_o;
  logic [3:0]  wstrb_o;
  logic        bvalid_i, bready_o;
  logic [1:0]  bresp_i;
  logic [3:0]  bid_i;

  sdram_stream_writer #(
    .BURST_LEN (BURST_LEN),
    .FIFO_DEPTH(FIFO_DEPTH),
    .AXI_ID    (4'd0)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .len_i(len_i),
    .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
    .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o),
    .awid_o(awid_o), .awlen_o(awlen_o), .awburst_o(awburst_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o),
    .wstrb_o(wstrb_o), .wlast_o(wlast_o),
    .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i), .bid_i(bid_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } aw_t;

  aw_t         awq[$];
  logic [31:0] wq[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // Per-transfer knobs and bookkeeping.
  int          stall_pct, aw_delay, err_burst, inj_cyc;
  bit          wtoggle;
  int          accepted, wbeats, aw_cnt, b_idx, axi_act, full_seen;
  int          aw_wait, wbeat, done_cyc, last_b_cyc;
  bit          b_pending, done_seen, aw_held, aw_prev, busy_at_done;
  logic [31:0] held_addr, word_idx;
  logic [7:0]  held_len, cur_awlen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_s_ready"}, s_ready_o, 0);
    check({pfx, "_busy"},    busy_o,    0);
    check({pfx, "_done"},    done_o,    0);
    check({pfx, "_error"},   error_o,   0);
    check({pfx, "_awvalid"}, awvalid_o, 0);
    check({pfx, "_awaddr"},  awaddr_o,  0);
    check({pfx, "_awlen"},   awlen_o,   0);
    check({pfx, "_wvalid"},  wvalid_o,  0);
    check({pfx, "_wlast"},   wlast_o,   0);
    check({pfx, "_wdata"},   wdata_o,   0);
    check({pfx, "_bready"},  bready_o,  0);
    check({pfx, "_awburst"}, awburst_o, 2'b01);
    check({pfx, "_wstrb"},   wstrb_o,   4'hF);
    check({pfx, "_awid"},    awid_o,    4'd0);
  endtask

  // One clock: at the falling edge drive inputs for the next rising edge, then
  // score every handshake that rising edge will complete.
  task automatic tick();
    logic [31:0] d;
    aw_t         e;
    @(negedge clk_i);
    cyc++;
    start_i = (cyc == inj_cyc);
    if (start_i) begin
      base_addr_i = 32'hDEAD_0000;
      len_i       = 24'd5;
    end
    s_valid_i = (stall_pct == 0) || ($urandom_range(99) >= stall_pct);
    s_data_i  = 32'hC0DE_0000 + word_idx;
    awready_i = awvalid_o && (aw_wait >= aw_delay);
    wready_i  = wtoggle ? 1'(cyc % 2) : 1'b1;
    bvalid_i  = b_pending;
    bresp_i   = (b_idx == err_burst) ? 2'b10 : 2'b00;

    if (done_o && !done_seen) begin
      done_seen    = 1'b1;
      done_cyc     = cyc;
      busy_at_done = busy_o;
    end
    if (awvalid_o || wvalid_o || bready_o) axi_act++;

    if (wq.size() == FIFO_DEPTH) begin
      full_seen++;
      check("full_ready", s_ready_o, 0);
    end

    if (awvalid_o && !aw_prev && awq.size() > 0)
      check("aw_fill", wq.size() >= int'(awq[0].len) + 1, 1);
    if (awvalid_o) begin
      if (aw_held) begin
        check("aw_addr_hold", awaddr_o, held_addr);
        check("aw_len_hold",  awlen_o,  held_len);
      end
      if (awready_i) begin
        if (awq.size() == 0) check("aw_extra", 1, 0);
        else begin
          e = awq.pop_front();
          check("aw_addr", awaddr_o, e.addr);
          check("aw_len",  awlen_o,  e.len);
          cur_awlen = e.len;
        end
        wbeat   = 0;
        aw_cnt++;
        aw_wait = 0;
        aw_held = 1'b0;
      end else begin
        aw_held   = 1'b1;
        held_addr = awaddr_o;
        held_len  = awlen_o;
        aw_wait++;
      end
    end
    aw_prev = awvalid_o;

    if (wvalid_o && wready_i) begin
      if (wq.size() == 0) check("w_extra", 1, 0);
      else begin
        d = wq.pop_front();
        check("w_data", wdata_o, d);
      end
      check("w_last", wlast_o, (wbeat == int'(cur_awlen)));
      if (wbeat == int'(cur_awlen)) b_pending = 1'b1;
      wbeat++;
      wbeats++;
    end

    if (bvalid_i && bready_o) begin
      b_pending  = 1'b0;
      b_idx++;
      last_b_cyc = cyc;
    end

    if (s_valid_i && s_ready_o) begin
      wq.push_back(s_data_i);
      word_idx++;
      accepted++;
    end
  endtask

  // Starts a transfer (call right after a falling edge) and scores it to done_o.
  // abort_beats > 0 returns early once that many W beats are committed.
  task automatic run_xfer(input logic [31:0] base, input logic [23:0] len,
                          input int stall, input int awd, input bit wtog,
                          input int errb, input int inj, input int abort_beats);
    logic [31:0] a;
    int          rem, nb, n, c0;
    bit          exp_err;
    aw_t         e;
    awq.delete();
    wq.delete();
    accepted = 0; wbeats = 0; aw_cnt = 0; b_idx = 0; axi_act = 0; full_seen = 0;
    aw_wait = 0; wbeat = 0; done_cyc = -1; last_b_cyc = -100;
    b_pending = 0; done_seen = 0; aw_held = 0; aw_prev = 0; cur_awlen = 0;
    stall_pct = stall; aw_delay = awd; wtoggle = wtog; err_burst = errb;

    a = base & ~32'h3F;
    rem = int'(len);
    nb = 0;
    while (rem > 0) begin
      n = (rem < BURST_LEN) ? rem : BURST_LEN;
      e.addr = a;
      e.len  = 8'(n - 1);
      awq.push_back(e);
      a = a + 32'(n * 4);
      rem -= n;
      nb++;
    end
    exp_err = (errb >= 0) && (errb < nb);

    base_addr_i = base;
    len_i       = len;
    start_i     = 1'b1;
    c0          = cyc;
    inj_cyc     = (inj > 0) ? c0 + inj : -1;
    tick();
    check("start_busy", busy_o, 1);
    check("start_err_clr", error_o, 0);

    n = 0;
    while (!done_seen && n < 4000) begin
      if (abort_beats > 0 && wbeats >= abort_beats) return;
      tick();
      n++;
    end

    check("done_seen", done_seen, 1);
    if (done_seen) begin
      check("done_busy_low", busy_at_done, 0);
      check("done_error", error_o, exp_err);
      check("accepted", accepted, int'(len));
      check("w_beats", wbeats, int'(len));
      check("aw_count", aw_cnt, nb);
      check("aw_left", awq.size(), 0);
      check("w_left", wq.size(), 0);
      if (len == 24'd0) begin
        check("len0_done_cyc", done_cyc, c0 + 2);
        check("len0_axi_idle", axi_act, 0);
      end else begin
        check("done_after_b", done_cyc, last_b_cyc + 1);
      end
      tick();
      check("done_pulse", done_o, 0);
      check("err_sticky", error_o, exp_err);
      check("idle_ready", s_ready_o, 0);
      check("idle_awvalid", awvalid_o, 0);
    end
  endtask

  initial begin
    rst_i = 1'b0; start_i = 1'b0; base_addr_i = '0; len_i = '0;
    s_valid_i = 1'b0; s_data_i = '0; awready_i = 1'b0; wready_i = 1'b0;
    bvalid_i = 1'b0; bresp_i = 2'b00; bid_i = 4'hA;
    word_idx = '0; inj_cyc = -1; stall_pct = 0; aw_delay = 0; wtoggle = 0;
    err_burst = -1; b_pending = 0; aw_prev = 0; aw_held = 0;

    #1 rst_i = 1'b1;
    #1 check_reset("rst");
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;

    // Aligned two-burst transfer with a continuous stream.
    run_xfer(32'h0000_1000, 24'd32, 0, 0, 1'b0, -1, 0, 0);
    // Short tail under a stalling stream.
    run_xfer(32'h0000_8000, 24'd20, 40, 0, 1'b0, -1, 0, 0);
    // Backpressure on AW, W and the stream; the FIFO must fill.
    run_xfer(32'h0001_0000, 24'd96, 25, 5, 1'b1, -1, 0, 0);
    check("fifo_full_seen", full_seen > 0, 1);
    // SLVERR on the first burst.
    run_xfer(32'h0000_4000, 24'd32, 0, 0, 1'b0, 0, 0, 0);
    // Zero length right after an error: error clears, no AXI traffic.
    run_xfer(32'h0000_5000, 24'd0, 0, 0, 1'b0, -1, 0, 0);
    // A second start while busy is ignored.
    run_xfer(32'h0000_6000, 24'd24, 0, 2, 1'b0, -1, 10, 0);
    // Unaligned base forced down, tail burst address wraps past 2^32.
    run_xfer(32'hFFFF_FFC4, 24'd20, 0, 0, 1'b0, -1, 0, 0);

    // Reset mid-burst, then a clean 16-word transfer.
    run_xfer(32'h0000_2000, 24'd32, 0, 0, 1'b0, -1, 0, 5);
    @(posedge clk_i);
    #1 check("pre_rst_wvalid", wvalid_o, 1);
    rst_i = 1'b1;
    s_valid_i = 1'b0; awready_i = 1'b0; wready_i = 1'b0; bvalid_i = 1'b0;
    start_i = 1'b0;
    #1 check_reset("mid");
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    run_xfer(32'h0000_3000, 24'd16, 0, 0, 1'b0, -1, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
